// File: rtl/crc_frame_check_if.sv
// Byte stream bundle used on both sides of crc_frame_check.
// The master drives data/valid/last, and the slave returns ready.
interface crc_frame_check_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc_frame_check.sv
// crc_frame_check: receive-side frame checker.
// It runs a CRC over every frame, including its trailing FCS, and checks the
// final register against the polynomial residue. It strips the FCS bytes
// through a FCS_BYTES-deep delay buffer and forwards the payload with
// ready/valid flow control. It also emits one status pulse per frame.
// Optional feature macro: CRC_FRAME_CHECK_LEN_EN (frame length counter and
// oversize detection). When the macro is undefined, frame_len and
// status_oversize read as zero.
module crc_frame_check #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
  parameter                        LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter logic [LFSR_WIDTH-1:0] RESIDUE     = 32'hdebb20e3,
  parameter int                    MAX_LEN     = 1518
) (
  input  logic                clk,
  input  logic                rst_n,
  crc_frame_check_if.slave    s,
  crc_frame_check_if.master   m,
  output logic                status_valid,
  output logic                status_good,
  output logic                status_bad_crc,
  output logic                status_runt,
  output logic                status_oversize,
  output logic [15:0]         frame_len
);

  localparam int FCS_BYTES = LFSR_WIDTH / 8;
  localparam int CNT_W     = $clog2(FCS_BYTES + 1);
  localparam bit CFG_GALOIS = (LFSR_CONFIG == "GALOIS");

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REF = reflect(LFSR_POLY);

  // One byte of LFSR next-state. With REVERSE, bits enter LSB first and the
  // register shifts right against the mirrored polynomial. That form matches
  // the residue convention of the RESIDUE parameter.
  function automatic logic [LFSR_WIDTH-1:0] crc_byte(input logic [LFSR_WIDTH-1:0] c,
                                                     input logic [7:0]            d);
    logic [LFSR_WIDTH-1:0] r;
    logic                  fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (REVERSE) begin
        if (CFG_GALOIS) begin
          fb = r[0] ^ d[i];
          r  = (r >> 1) ^ (fb ? POLY_REF : '0);
        end else begin
          fb = d[i] ^ (^(r & POLY_REF));
          r  = {fb, r[LFSR_WIDTH-1:1]};
        end
      end else begin
        if (CFG_GALOIS) begin
          fb = r[LFSR_WIDTH-1] ^ d[7-i];
          r  = (r << 1) ^ (fb ? LFSR_POLY : '0);
        end else begin
          fb = d[7-i] ^ (^(r & LFSR_POLY));
          r  = {r[LFSR_WIDTH-2:0], fb};
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [LFSR_WIDTH-1:0] crc;
  logic [7:0]            dly_p0 [FCS_BYTES];

  logic                  accept;
  logic [LFSR_WIDTH-1:0] crc_nxt;
  logic                  frame_runt;
  logic                  crc_match;
  logic [15:0]           len_nxt;
  logic                  len_over;

  // In STREAM each accepted byte pushes into the output register, so accept
  // only when that register is empty or is draining this cycle.
  assign s.ready    = (state != STREAM) || !m.valid || m.ready;
  assign accept     = s.valid && s.ready;
  assign crc_nxt    = crc_byte(crc, s.data);
  assign frame_runt = (state != STREAM);
  assign crc_match  = (crc_nxt == RESIDUE);

`ifdef CRC_FRAME_CHECK_LEN_EN
  logic [15:0] len_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  assign len_nxt  = sat_inc16(len_p0);
  assign len_over = (int'(len_nxt) > MAX_LEN);

  // Running byte count of the current frame, FCS included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      len_p0 <= '0;
    else if (accept)
      len_p0 <= s.last ? 16'd0 : len_nxt;
  end
`else
  assign len_nxt  = '0;
  assign len_over = 1'b0;
`endif

  // Frame FSM: delay buffer, CRC state, output register and status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      crc             <= LFSR_INIT;
      for (int i = 0; i < FCS_BYTES; i++) dly_p0[i] <= '0;
      m.data          <= '0;
      m.valid         <= 1'b0;
      m.last          <= 1'b0;
      status_valid    <= 1'b0;
      status_good     <= 1'b0;
      status_bad_crc  <= 1'b0;
      status_runt     <= 1'b0;
      status_oversize <= 1'b0;
      frame_len       <= '0;
    end else begin
      status_valid <= 1'b0;
      if (m.valid && m.ready) m.valid <= 1'b0;

      if (accept) begin
        if (state == STREAM) begin
          m.data  <= dly_p0[0];
          m.valid <= 1'b1;
          m.last  <= s.last;
        end

        if (s.last) begin
          // End of frame: the bytes left in the buffer are the FCS, so drop them.
          state           <= IDLE;
          cnt             <= '0;
          crc             <= LFSR_INIT;
          for (int i = 0; i < FCS_BYTES; i++) dly_p0[i] <= '0;
          status_valid    <= 1'b1;
          status_runt     <= frame_runt;
          status_bad_crc  <= !frame_runt && !crc_match;
          status_good     <= !frame_runt && crc_match && !len_over;
          status_oversize <= len_over;
          frame_len       <= len_nxt;
        end else begin
          crc <= crc_nxt;
          for (int i = 0; i < FCS_BYTES - 1; i++) dly_p0[i] <= dly_p0[i+1];
          dly_p0[FCS_BYTES-1] <= s.data;
          if (state != STREAM) begin
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_W'(FCS_BYTES - 1)) ? STREAM : FILL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_check.sv
// Testbench for crc_frame_check: directed frames plus randomized frames with
// random gaps and downstream backpressure. The reference model is a
// table-driven CRC-32 used only to build the FCS. Expected status comes from
// how each frame was built (length, deliberate corruption).
module tb_crc_frame_check;
  localparam int FCS = 4;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic good;
    logic bad;
    logic runt;
    logic over;
    int   len;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        status_valid, status_good, status_bad_crc, status_runt, status_oversize;
  logic [15:0] frame_len;

  crc_frame_check_if s_if ();
  crc_frame_check_if m_if ();

  crc_frame_check dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s               (s_if),
    .m               (m_if),
    .status_valid    (status_valid),
    .status_good     (status_good),
    .status_bad_crc  (status_bad_crc),
    .status_runt     (status_runt),
    .status_oversize (status_oversize),
    .frame_len       (frame_len)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [31:0] crc_tab [256];
  logic [8:0]  pay_q [$];
  stat_t       stat_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input byte_q_t q);
    logic [31:0] c;
    c = 32'hffff_ffff;
    foreach (q[i]) c = crc_tab[(c[7:0] ^ q[i])] ^ (c >> 8);
    return ~c;
  endfunction

  // FCS goes out least significant byte first.
  function automatic byte_q_t with_fcs(input byte_q_t pay);
    byte_q_t     f;
    logic [31:0] c;
    f = pay;
    c = crc32(pay);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  // Queue up what the checker should report for a frame.
  task automatic expect_frame(input byte_q_t frm, input bit fcs_ok);
    stat_t e;
    int    n;
    n      = frm.size();
    e.runt = (n <= FCS);
`ifdef CRC_FRAME_CHECK_LEN_EN
    e.over = (n > 1518);
    e.len  = n;
`else
    e.over = 1'b0;
    e.len  = 0;
`endif
    e.good = !e.runt && fcs_ok && !e.over;
    e.bad  = !e.runt && !fcs_ok;
    stat_q.push_back(e);
    if (!e.runt)
      for (int i = 0; i < n - FCS; i++) pay_q.push_back({(i == n - FCS - 1), frm[i]});
  endtask

  task automatic send_frame(input byte_q_t frm, input bit gaps, input bit mark_last);
    int n;
    bit acc;
    foreach (frm[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_if.valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      s_if.valid = 1'b1;
      s_if.data  = frm[i];
      s_if.last  = mark_last && (i == frm.size() - 1);
      n = 0;
      forever begin
        @(negedge clk);
        acc = s_if.ready;
        @(posedge clk);
        #1;
        if (acc) break;
        n++;
        if (n > 200) begin
          check("accept_timeout", 1, 0);
          break;
        end
      end
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern.
  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.ready = 1'b1;
        1:       m_if.ready = ~m_if.ready;
        default: m_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitors: payload, input stall rule, status contents and status latency.
  int acc_cnt  = 0;
  int last_cyc = -10;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cnt = 0;
    end else begin
      if (m_if.valid && m_if.ready) begin
        if (pay_q.size() == 0) check("unexpected_payload", {24'd0, m_if.data}, 32'hffff_ffff);
        else begin
          logic [8:0] e;
          e = pay_q.pop_front();
          check("m_data", m_if.data, e[7:0]);
          check("m_last", m_if.last, e[8]);
        end
      end
      if (m_if.valid && !m_if.ready && acc_cnt >= FCS) check("s_ready_stall", s_if.ready, 0);
      if (status_valid) begin
        check("status_latency", cyc, last_cyc + 1);
        if (stat_q.size() == 0) check("unexpected_status", 1, 0);
        else begin
          stat_t e;
          e = stat_q.pop_front();
          check("status_good", status_good, e.good);
          check("status_bad_crc", status_bad_crc, e.bad);
          check("status_runt", status_runt, e.runt);
          check("status_oversize", status_oversize, e.over);
          check("frame_len", frame_len, e.len);
        end
      end
      if (s_if.valid && s_if.ready) begin
        if (s_if.last) begin
          acc_cnt  = 0;
          last_cyc = cyc;
        end else acc_cnt++;
      end
    end
  end

  initial begin
    byte_q_t good9, bad9, runt3, fa, fb, part, pay;
    int      w;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
      crc_tab[n] = c;
    end

    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_m_valid", m_if.valid, 0);
    check("rst_m_last", m_if.last, 0);
    check("rst_m_data", m_if.data, 0);
    check("rst_s_ready", s_if.ready, 1);
    check("rst_status_valid", status_valid, 0);
    check("rst_status_good", status_good, 0);
    check("rst_status_flags", {status_bad_crc, status_runt, status_oversize}, 0);
    check("rst_frame_len", frame_len, 0);
    @(posedge clk);
    #1;

    // Known check value: CRC-32("123456789") = CBF43926.
    good9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hf4, 8'hcb};
    expect_frame(good9, 1'b1);
    send_frame(good9, 1'b0, 1'b1);

    bad9 = good9;
    bad9[4] = 8'h36;
    expect_frame(bad9, 1'b0);
    send_frame(bad9, 1'b0, 1'b1);

    runt3 = '{8'haa, 8'hbb, 8'hcc};
    expect_frame(runt3, 1'b0);
    send_frame(runt3, 1'b0, 1'b1);

    // Backpressure: ready toggles every cycle.
    rdy_mode = 1;
    expect_frame(good9, 1'b1);
    send_frame(good9, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1 rdy_mode = 0;

    // Back-to-back frames without an idle cycle between them.
    pay.delete();
    for (int i = 0; i < 7; i++) pay.push_back(8'($urandom));
    fa = with_fcs(pay);
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
    fb = with_fcs(pay);
    expect_frame(fa, 1'b1);
    expect_frame(fb, 1'b1);
    send_frame(fa, 1'b0, 1'b1);
    send_frame(fb, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Reset after 6 bytes: the first two payload bytes drain before reset.
    // No status pulse is expected for the partial frame.
    part.delete();
    for (int i = 0; i < 6; i++) part.push_back(8'($urandom));
    pay_q.push_back({1'b0, part[0]});
    pay_q.push_back({1'b0, part[1]});
    send_frame(part, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_if.valid, 0);
    check("midrst_s_ready", s_if.ready, 1);
    @(posedge clk);
    #1;
    expect_frame(good9, 1'b1);
    send_frame(good9, 1'b0, 1'b1);

    // Randomized frames: lengths, corruption, gaps and ready pattern.
    for (int f = 0; f < 30; f++) begin
      byte_q_t frm;
      bit      corrupt;
      rdy_mode = $urandom_range(0, 2);
      pay.delete();
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < $urandom_range(1, FCS); i++) pay.push_back(8'($urandom));
        frm = pay;
        expect_frame(frm, 1'b0);
      end else begin
        for (int i = 0; i < $urandom_range(1, 40); i++) pay.push_back(8'($urandom));
        frm = with_fcs(pay);
        corrupt = ($urandom_range(0, 2) == 0);
        if (corrupt) begin
          int idx;
          idx = $urandom_range(0, frm.size() - 1);
          frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
        end
        expect_frame(frm, !corrupt);
      end
      send_frame(frm, 1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef CRC_FRAME_CHECK_LEN_EN
    // Oversize: 1516 payload bytes + FCS = 1520 > 1518.
    rdy_mode = 0;
    pay.delete();
    for (int i = 0; i < 1516; i++) pay.push_back(8'($urandom));
    fa = with_fcs(pay);
    expect_frame(fa, 1'b1);
    send_frame(fa, 1'b0, 1'b1);
`endif

    rdy_mode = 0;
    w = 0;
    while ((pay_q.size() != 0 || stat_q.size() != 0) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    check("drain_payload", pay_q.size(), 0);
    check("drain_status", stat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_check.md
# crc_frame_check

Byte-stream receive-side frame checker that sits directly downstream of the deserialiser and wraps the codebase's `lfsr` next-state logic. It runs a CRC over each frame including its trailing FCS, then compares the final register against the polynomial's residue. It strips the FCS bytes and forwards the payload downstream with ready/valid flow control. It reports one status pulse per frame: good, bad CRC, runt, and optionally length and oversize.

## Interface
- `LFSR_WIDTH`, 32: CRC width. Must be a multiple of 8. `FCS_BYTES` = `LFSR_WIDTH`/8.
- `LFSR_POLY`, 32'h04c11db7: polynomial, with the top term implicit.
- `LFSR_INIT`, all ones: CRC state at the start of each frame.
- `LFSR_CONFIG`, "GALOIS": passed to `lfsr`.
- `REVERSE`, 1: LSB-first bit order, passed to `lfsr`.
- `RESIDUE`, 32'hdebb20e3: raw (non-inverted) state expected after a good frame's FCS.
- `MAX_LEN`, 1518: oversize threshold in payload+FCS bytes. Only used with `CRC_FRAME_CHECK_LEN_EN`.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data` in 8: input byte.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: block accepts the input byte.
- `s_last` in 1: final byte of the frame (the last FCS byte).
- `m_data` out 8: payload byte.
- `m_valid` out 1: payload byte valid.
- `m_ready` in 1: downstream accepts the payload byte.
- `m_last` out 1: last payload byte of the frame.
- `status_valid` out 1: one-cycle pulse per completed frame.
- `status_good` out 1: CRC matched and frame not runt.
- `status_bad_crc` out 1: CRC mismatch.
- `status_runt` out 1: frame had ≤ `FCS_BYTES` bytes.
- `status_oversize` out 1: frame length exceeded `MAX_LEN`.
- `frame_len` out 16: total bytes of the frame, FCS included.

## Operation
- An input byte is accepted when `s_valid && s_ready`. The CRC state updates on each accepted byte via `lfsr` (`DATA_WIDTH`=8).
- Delay buffer: `FCS_BYTES` byte slots plus a count of 0..`FCS_BYTES`.
- States:
  - IDLE (count 0) → FILL on the first accepted byte.
  - FILL (count < `FCS_BYTES`): byte is appended, `s_ready`=1.
  - STREAM (count = `FCS_BYTES`): each accepted byte pushes the oldest slot into the output register.
- Output register:
  - `s_ready` in STREAM = `!m_valid || m_ready`.
  - The pushed byte sets `m_valid`=1.
  - `m_last` = `s_last` of the accepting byte.
- On an accepted `s_last`:
  - The buffer is cleared, the state returns to IDLE, and CRC state reloads `LFSR_INIT`.
  - The next-state value is compared with `RESIDUE` and the status is registered.
  - The remaining `FCS_BYTES` bytes are discarded and never appear on `m_*`.
- Runt: `s_last` accepted while in IDLE/FILL.
  - No `m_*` output for that frame.
  - `status_runt`=1, `status_good`=0, `status_bad_crc`=0.
- `status_good` = !runt && match && !oversize.
- `status_bad_crc` = !runt && !match.
- `frame_len` saturates at 16'hffff.
- A new frame may start on the byte immediately after `s_last`, with no bubble.

## Timing
- Reset values:
  - `m_valid`=0, `m_last`=0, `m_data`=0, `s_ready`=1.
  - `status_*`=0, `frame_len`=0.
  - State IDLE, CRC = `LFSR_INIT`.
- Payload latency: a byte appears on `m_*` the cycle after the (`FCS_BYTES`)-later byte is accepted.
- Status latency: `status_valid` pulses exactly one cycle after `s_last` is accepted. Status fields hold until the next pulse.
- `status_valid` ignores `m_ready`. It may assert while the last payload byte is still stalled on `m_*`.
- Full throughput: one byte per clock when `m_ready`=1.
- Reset mid-frame: the partial frame is dropped with no status pulse, and the buffer is flushed.

## Configuration
- `CRC_FRAME_CHECK_LEN_EN` defined:
  - 16-bit length counter is present; `frame_len` is valid with `status_valid`.
  - `status_oversize` = length > `MAX_LEN`, and oversize forces `status_good`=0.
- `CRC_FRAME_CHECK_LEN_EN` undefined: counter is omitted, `frame_len`=0, `status_oversize`=0.

## Test plan
- Good frame: "123456789" (31..39) followed by FCS 26 39 F4 CB, `m_ready`=1.
  - `m_*` emits 31..39 with `m_last` on 0x39.
  - `status_good`=1; `frame_len`=13 (LEN_EN).
- Same frame with byte 0x35 corrupted to 0x36: 9 payload bytes forwarded, `status_bad_crc`=1, `status_good`=0.
- Runt: 3-byte frame AA BB CC with `s_last` on CC → no `m_valid`, `status_runt`=1.
- Backpressure: good frame with `m_ready` toggling 1/0 every cycle.
  - Payload order is intact.
  - `s_ready` is low whenever `m_valid && !m_ready` in STREAM.
  - `status_good`=1.
- Back-to-back: two good frames with no idle cycle between them → two status pulses, both good, payloads correctly delimited.
- `rst_n` asserted after 6 bytes of a frame, then a good frame is sent → no status for the partial frame, second frame good.
